// File: rtl/mz_reset_ce_gen.sv
// Reset sequencer and CPU clock-enable generator for the Sharp MZ cores.
// N asynchronous reset requests are synchronised and OR-ed, then stretched into
// a registered system reset. A selectable divider produces cpu_ce / cpu_ce_n.
// Speed changes are applied only at a period boundary, so they never glitch.
module mz_reset_ce_gen #(
  parameter int RST_CNT_W = 8,
  parameter int NSRC      = 4,
  parameter int NMODES    = 4,
  parameter int DIV_W     = 8,
  parameter logic [DIV_W*NMODES-1:0] DIV_LIST = 32'h02_04_08_10,
  parameter int DEF_MODE  = 0,
  localparam int MODE_W   = (NMODES > 1) ? $clog2(NMODES) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [NSRC-1:0]   rst_req,
  input  logic [MODE_W-1:0] mode_sel,
  output logic              sys_reset,
  output logic              sys_reset_n,
  output logic              cpu_ce,
  output logic              cpu_ce_n,
  output logic [MODE_W-1:0] mode_cur
);

  localparam int NTAB = 1 << MODE_W;

  // Divisor per encodable mode; entries below 2 are raised to 2, and codes
  // beyond NMODES get a harmless 2 (they are never accepted anyway).
  function automatic logic [NTAB*DIV_W-1:0] build_div_tab();
    logic [NTAB*DIV_W-1:0] t;
    logic [DIV_W-1:0]      d;
    for (int i = 0; i < NTAB; i++) t[DIV_W*i +: DIV_W] = DIV_W'(2);
    for (int i = 0; i < NMODES; i++) begin
      d = DIV_LIST[DIV_W*i +: DIV_W];
      if (d < DIV_W'(2)) d = DIV_W'(2);
      t[DIV_W*i +: DIV_W] = d;
    end
    return t;
  endfunction

  // One bit per encodable mode code: set when the code names a real mode.
  function automatic logic [NTAB-1:0] build_mode_ok();
    logic [NTAB-1:0] ok;
    ok = '0;
    for (int i = 0; i < NMODES; i++) ok[i] = 1'b1;
    return ok;
  endfunction

  localparam logic [NTAB*DIV_W-1:0] DIV_TAB = build_div_tab();
  localparam logic [NTAB-1:0]       MODE_OK = build_mode_ok();
  localparam logic [MODE_W-1:0]     DEF_M   = MODE_W'(DEF_MODE);
  localparam logic [RST_CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [DIV_W-1:0]      DEF_D   = DIV_TAB[DIV_W*DEF_MODE +: DIV_W];

  function automatic logic [DIV_W-1:0] div_of(input logic [MODE_W-1:0] m);
    return DIV_TAB[DIV_W*int'(m) +: DIV_W];
  endfunction

  logic [NSRC-1:0]      req_s1, req_s2;
  logic                 req_s;
  logic [RST_CNT_W-1:0] cnt, cnt_nx;
  logic                 rst_nx;
  logic [MODE_W-1:0]    mode_s1, mode_s2, pend, pend_nx, mode_nx;
  logic [DIV_W-1:0]     div_d, div_nx, div_cnt, div_cnt_nx;
  logic                 hold;

  // Next-state for stretch counter, mode filter and divider.
  always_comb begin
    req_s  = |req_s2;
    cnt_nx = cnt;
    if (req_s)               cnt_nx = '0;
    else if (cnt != CNT_MAX) cnt_nx = cnt + 1'b1;
    rst_nx = (cnt_nx != CNT_MAX);

    // Accept only a value seen on two consecutive synchroniser outputs.
    pend_nx = pend;
    if (mode_s1 == mode_s2 && MODE_OK[mode_s2]) pend_nx = mode_s2;

    // Hold the divider on the cycle reset rises and the cycle it falls, so
    // div_cnt reads 1 one edge after sys_reset drops.
    hold       = sys_reset | rst_nx;
    div_cnt_nx = div_cnt + 1'b1;
    div_nx     = div_d;
    mode_nx    = mode_cur;
    if (hold) begin
      div_cnt_nx = '0;
      div_nx     = div_of(pend_nx);
      mode_nx    = pend_nx;
    end else if (div_cnt == div_d - 1'b1) begin
      div_cnt_nx = '0;
      div_nx     = div_of(pend_nx);
      mode_nx    = pend_nx;
    end
  end

  // All state and registered outputs; pulses are decoded from next-state so
  // they line up with div_cnt.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      req_s1      <= '0;
      req_s2      <= '0;
      cnt         <= '0;
      sys_reset   <= 1'b1;
      sys_reset_n <= 1'b0;
      mode_s1     <= '0;
      mode_s2     <= '0;
      pend        <= DEF_M;
      mode_cur    <= DEF_M;
      div_d       <= DEF_D;
      div_cnt     <= '0;
      cpu_ce      <= 1'b0;
      cpu_ce_n    <= 1'b0;
    end else begin
      req_s1      <= rst_req;
      req_s2      <= req_s1;
      cnt         <= cnt_nx;
      sys_reset   <= rst_nx;
      sys_reset_n <= ~rst_nx;
      mode_s1     <= mode_sel;
      mode_s2     <= mode_s1;
      pend        <= pend_nx;
      mode_cur    <= mode_nx;
      div_d       <= div_nx;
      div_cnt     <= div_cnt_nx;
      cpu_ce      <= !hold && (div_cnt_nx == div_nx - 1'b1);
      cpu_ce_n    <= !hold && (div_cnt_nx == (div_nx >> 1) - 1'b1);
    end
  end

endmodule

// File: tb/tb_mz_reset_ce_gen.sv
// Directed bench for mz_reset_ce_gen: a default instance (u1, 256-cycle stretch)
// and a small 3-mode instance with degenerate divisors (u2, 16-cycle stretch).
module tb_mz_reset_ce_gen;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [3:0] rst_req, rst_req2;
  logic [1:0] mode_sel, mode_sel2;
  logic       sys_reset, sys_reset_n, cpu_ce, cpu_ce_n;
  logic [1:0] mode_cur;
  logic       sys_reset2, sys_reset_n2, cpu_ce2, cpu_ce_n2;
  logic [1:0] mode_cur2;

  int nchk = 0;
  int nerr = 0;
  int ecnt = 0;

  always #5 clk_sys = ~clk_sys;

  mz_reset_ce_gen u1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .rst_req(rst_req), .mode_sel(mode_sel),
    .sys_reset(sys_reset), .sys_reset_n(sys_reset_n), .cpu_ce(cpu_ce),
    .cpu_ce_n(cpu_ce_n), .mode_cur(mode_cur)
  );

  // mode0 -> 4, mode1 -> 1 (used as 2), mode2 -> 0 (used as 2)
  mz_reset_ce_gen #(
    .RST_CNT_W(4), .NSRC(4), .NMODES(3), .DIV_W(8),
    .DIV_LIST(24'h00_01_04), .DEF_MODE(0)
  ) u2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .rst_req(rst_req2), .mode_sel(mode_sel2),
    .sys_reset(sys_reset2), .sys_reset_n(sys_reset_n2), .cpu_ce(cpu_ce2),
    .cpu_ce_n(cpu_ce_n2), .mode_cur(mode_cur2)
  );

  typedef struct {
    int   edge_no;
    logic rst;
    logic ce;
    logic cen;
    logic rst2;
    logic ce2;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", nm, ecnt, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    ecnt++;
  endtask

  task automatic to_edge(input int e);
    while (ecnt < e) tick();
  endtask

  // Cycles between two consecutive u2 cpu_ce pulses; 0 on timeout.
  task automatic period2(output int p);
    int n;
    p = 0;
    n = 0;
    while (!cpu_ce2 && n < 40) begin tick(); n++; end
    if (!cpu_ce2) return;
    n = 0;
    do begin tick(); n++; end while (!cpu_ce2 && n < 40);
    if (cpu_ce2) p = n;
  endtask

  initial begin
    int last, p, n;
    tbl[0]  = '{1,   1, 0, 0, 1, 0};
    tbl[1]  = '{14,  1, 0, 0, 1, 0};
    tbl[2]  = '{15,  1, 0, 0, 0, 0};
    tbl[3]  = '{17,  1, 0, 0, 0, 0};
    tbl[4]  = '{18,  1, 0, 0, 0, 1};
    tbl[5]  = '{22,  1, 0, 0, 0, 1};
    tbl[6]  = '{254, 1, 0, 0, 0, 1};
    tbl[7]  = '{255, 0, 0, 0, 0, 0};
    tbl[8]  = '{262, 0, 0, 1, 0, 1};
    tbl[9]  = '{263, 0, 0, 0, 0, 0};
    tbl[10] = '{269, 0, 0, 0, 0, 0};
    tbl[11] = '{270, 0, 1, 0, 0, 1};
    tbl[12] = '{271, 0, 0, 0, 0, 0};
    tbl[13] = '{278, 0, 0, 1, 0, 1};
    tbl[14] = '{286, 0, 1, 0, 0, 1};

    reset_n = 1'b0; rst_req = '0; rst_req2 = '0; mode_sel = '0; mode_sel2 = '0;
    repeat (5) @(posedge clk_sys);
    #1;
    chk("rst_sys_reset",   sys_reset,   1);
    chk("rst_sys_reset_n", sys_reset_n, 0);
    chk("rst_cpu_ce",      cpu_ce,      0);
    chk("rst_cpu_ce_n",    cpu_ce_n,    0);
    chk("rst_mode_cur",    mode_cur,    0);
    chk("rst_mode_cur2",   mode_cur2,   0);
    reset_n = 1'b1;

    // Power-up: stretch then the first CE periods on both instances.
    foreach (tbl[i]) begin
      to_edge(tbl[i].edge_no);
      chk("pu_sys_reset",   sys_reset,   tbl[i].rst);
      chk("pu_sys_reset_n", sys_reset_n, !tbl[i].rst);
      chk("pu_cpu_ce",      cpu_ce,      tbl[i].ce);
      chk("pu_cpu_ce_n",    cpu_ce_n,    tbl[i].cen);
      chk("pu_sys_reset2",  sys_reset2,  tbl[i].rst2);
      chk("pu_cpu_ce2",     cpu_ce2,     tbl[i].ce2);
    end

    // Mid-run one-cycle request on source 1, set before edge 287.
    rst_req = 4'b0010;
    tick();
    rst_req = '0;
    tick();
    chk("req_not_yet", sys_reset, 0);
    tick();
    chk("req_sys_reset", sys_reset, 1);
    chk("req_ce_stop",   cpu_ce,    0);
    to_edge(543);
    chk("req_stretch_end_m1", sys_reset, 1);
    tick();
    chk("req_stretch_end", sys_reset, 0);
    to_edge(558);
    chk("req_ce_before", cpu_ce, 0);
    tick();
    chk("req_ce_resume", cpu_ce, 1);

    // Mode 0 -> 3 in the middle of a 16-cycle period.
    to_edge(563);
    mode_sel = 2'd3;
    to_edge(575);
    chk("sw_ce_old_period", cpu_ce,   1);
    chk("sw_mode_old",      mode_cur, 0);
    tick();
    chk("sw_mode_new",  mode_cur, 3);
    chk("sw_ce_n_wrap", cpu_ce_n, 1);
    chk("sw_ce_wrap",   cpu_ce,   0);
    tick();
    chk("sw_ce_first_fast", cpu_ce, 1);
    last = ecnt;
    while (ecnt < 600) begin
      tick();
      if (cpu_ce && cpu_ce_n) chk("sw_overlap", 1, 0);
      if (cpu_ce) begin
        chk("sw_gap", ecnt - last, 2);
        last = ecnt;
      end
    end

    // Mode change while the reset is asserted (request and mode together).
    rst_req  = 4'b0001;
    mode_sel = 2'd2;
    to_edge(602);
    chk("mr_sys_reset_pre", sys_reset, 0);
    tick();
    chk("mr_sys_reset", sys_reset, 1);
    chk("mr_mode_cur",  mode_cur,  2);
    chk("mr_ce_off",    cpu_ce,    0);
    to_edge(605);
    rst_req = '0;
    to_edge(861);
    chk("mr_stretch_m1", sys_reset, 1);
    tick();
    chk("mr_stretch_end", sys_reset, 0);
    tick();
    chk("mr_ce_n_first", cpu_ce_n, 1);
    tick();
    chk("mr_ce_not_yet", cpu_ce, 0);
    tick();
    chk("mr_ce_first", cpu_ce, 1);
    to_edge(869);
    chk("mr_ce_period4", cpu_ce, 1);

    // Illegal mode code and clamped divisors on the 3-mode instance.
    mode_sel2 = 2'd3;
    repeat (10) tick();
    chk("il_mode_ignored", mode_cur2, 0);
    period2(p);
    chk("il_period_d4", p, 4);
    mode_sel2 = 2'd1;
    repeat (10) tick();
    chk("il_mode1", mode_cur2, 1);
    period2(p);
    chk("il_period_div1", p, 2);
    mode_sel2 = 2'd3;
    repeat (10) tick();
    chk("il_mode_kept", mode_cur2, 1);
    mode_sel2 = 2'd2;
    repeat (10) tick();
    chk("il_mode2", mode_cur2, 2);
    period2(p);
    chk("il_period_div0", p, 2);

    // Asynchronous reset while a CE pulse is high, between clock edges.
    n = 0;
    while (!cpu_ce && n < 10) begin tick(); n++; end
    chk("ar_ce_seen", cpu_ce, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_sys_reset",   sys_reset,   1);
    chk("ar_sys_reset_n", sys_reset_n, 0);
    chk("ar_cpu_ce",      cpu_ce,      0);
    chk("ar_cpu_ce_n",    cpu_ce_n,    0);
    chk("ar_mode_cur",    mode_cur,    0);
    chk("ar_mode_cur2",   mode_cur2,   0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
